// File: rtl/my_demux_reg_pkg.sv
// Shared types and defaults for the registered 1-to-3 demux path.
package my_demux_reg_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_X = 2'b11
  } sel_e;

endpackage

// File: rtl/my_demux_reg_if.sv
// Input stream plus three output channels and the drop counter of my_demux_reg.
interface my_demux_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] c;
  logic             c_valid;
  logic             c_ready;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_valid, in_data, s0, s1, a_ready, b_ready, c_ready,
    input  in_ready, a, a_valid, b, b_valid, c, c_valid, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, s0, s1, a_ready, b_ready, c_ready,
    output in_ready, a, a_valid, b, b_valid, c, c_valid, drop_cnt
  );
endinterface

// File: rtl/my_demux_slot.sv
// Single-entry valid/ready output register; free means it can take a beat this cycle.
module my_demux_slot
  import my_demux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);

  assign free = !valid || ready;

  // A load while draining overwrites the slot and keeps it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/my_demux_reg.sv
// Registered 1-to-3 demux: select decode, in_ready muxing and illegal-beat drop counter.
// Optional MY_DEMUX_BROADCAST_EN turns select 11 into a broadcast to all three channels.
module my_demux_reg
  import my_demux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic          clk,
  input logic          rst_n,
  my_demux_reg_if.slave bus
);

  sel_e sel;
  logic free_a, free_b, free_c;
  logic load_a, load_b, load_c;
  logic ready;
  logic drop_hit;

  assign sel          = sel_e'({bus.s1, bus.s0});
  assign bus.in_ready = ready;

  always_comb begin
    ready    = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_c   = 1'b0;
    drop_hit = 1'b0;
    unique case (sel)
      SEL_A: begin
        ready  = free_a;
        load_a = bus.in_valid && free_a;
      end
      SEL_B: begin
        ready  = free_b;
        load_b = bus.in_valid && free_b;
      end
      SEL_C: begin
        ready  = free_c;
        load_c = bus.in_valid && free_c;
      end
      SEL_X: begin
`ifdef MY_DEMUX_BROADCAST_EN
        ready  = free_a && free_b && free_c;
        load_a = bus.in_valid && ready;
        load_b = bus.in_valid && ready;
        load_c = bus.in_valid && ready;
`else
        ready    = 1'b1;
        drop_hit = bus.in_valid;
`endif
      end
    endcase
  end

  my_demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .din(bus.in_data), .ready(bus.a_ready),
    .data(bus.a), .valid(bus.a_valid), .free(free_a)
  );

  my_demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .din(bus.in_data), .ready(bus.b_ready),
    .data(bus.b), .valid(bus.b_valid), .free(free_b)
  );

  my_demux_slot #(.WIDTH(WIDTH)) u_slot_c (
    .clk(clk), .rst_n(rst_n), .load(load_c), .din(bus.in_data), .ready(bus.c_ready),
    .data(bus.c), .valid(bus.c_valid), .free(free_c)
  );

  logic [CNT_W-1:0] drop_q;

  // Saturating count of discarded illegal-select beats; stays zero when broadcasting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_hit && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_my_demux_reg.sv
// Directed self-checking bench for my_demux_reg: vector table plus illegal-select and reset sequences.
module tb_my_demux_reg;
  import my_demux_reg_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  my_demux_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  my_demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic       ra, rb, rc;
    logic       e_rdy;
    logic       e_av, e_bv, e_cv;
    logic [7:0] e_a, e_b, e_c;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic v, logic [1:0] sel, logic [7:0] d, logic ra, logic rb,
                              logic rc, logic e_rdy, logic e_av, logic e_bv, logic e_cv,
                              logic [7:0] e_a, logic [7:0] e_b, logic [7:0] e_c);
    vec_t r;
    r.v = v; r.sel = sel; r.d = d; r.ra = ra; r.rb = rb; r.rc = rc;
    r.e_rdy = e_rdy; r.e_av = e_av; r.e_bv = e_bv; r.e_cv = e_cv;
    r.e_a = e_a; r.e_b = e_b; r.e_c = e_c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic ra, input logic rb, input logic rc);
    bus.in_valid = v;
    {bus.s1, bus.s0} = sel;
    bus.in_data = d;
    bus.a_ready = ra;
    bus.b_ready = rb;
    bus.c_ready = rc;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1);

    vecs[0]  = mk(1, 2'b00, 8'h5A, 1, 1, 1, 1, 1, 0, 0, 8'h5A, 8'h00, 8'h00);
    vecs[1]  = mk(0, 2'b00, 8'h00, 1, 0, 1, 1, 0, 0, 0, 8'h5A, 8'h00, 8'h00);
    vecs[2]  = mk(1, 2'b01, 8'h11, 1, 0, 1, 1, 0, 1, 0, 8'h5A, 8'h11, 8'h00);
    vecs[3]  = mk(1, 2'b01, 8'h22, 1, 0, 1, 0, 0, 1, 0, 8'h5A, 8'h11, 8'h00);
    vecs[4]  = mk(1, 2'b10, 8'h33, 1, 0, 1, 1, 0, 1, 1, 8'h5A, 8'h11, 8'h33);
    vecs[5]  = mk(1, 2'b01, 8'h22, 1, 1, 1, 1, 0, 1, 0, 8'h5A, 8'h22, 8'h33);
    vecs[6]  = mk(0, 2'b01, 8'h00, 1, 1, 1, 1, 0, 0, 0, 8'h5A, 8'h22, 8'h33);
    vecs[7]  = mk(1, 2'b00, 8'h01, 1, 1, 1, 1, 1, 0, 0, 8'h01, 8'h22, 8'h33);
    vecs[8]  = mk(1, 2'b00, 8'h02, 1, 1, 1, 1, 1, 0, 0, 8'h02, 8'h22, 8'h33);
    vecs[9]  = mk(1, 2'b00, 8'h03, 1, 1, 1, 1, 1, 0, 0, 8'h03, 8'h22, 8'h33);
    vecs[10] = mk(1, 2'b00, 8'h04, 1, 1, 1, 1, 1, 0, 0, 8'h04, 8'h22, 8'h33);
    vecs[11] = mk(0, 2'b00, 8'h00, 1, 1, 1, 1, 0, 0, 0, 8'h04, 8'h22, 8'h33);
    vecs[12] = mk(1, 2'b00, 8'h99, 0, 1, 1, 1, 1, 0, 0, 8'h99, 8'h22, 8'h33);
    vecs[13] = mk(1, 2'b00, 8'hAA, 0, 1, 1, 0, 1, 0, 0, 8'h99, 8'h22, 8'h33);
    vecs[14] = mk(1, 2'b01, 8'hBB, 0, 1, 1, 1, 1, 1, 0, 8'h99, 8'hBB, 8'h33);
    vecs[15] = mk(0, 2'b00, 8'h00, 1, 1, 1, 1, 0, 0, 0, 8'h99, 8'hBB, 8'h33);

    // Reset values
    #2;
    chk("rst_valids", {29'd0, bus.a_valid, bus.b_valid, bus.c_valid}, 32'd0);
    chk("rst_data", {8'd0, bus.a, bus.b, bus.c}, 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ra, vecs[i].rb, vecs[i].rc);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valids", i), {29'd0, bus.a_valid, bus.b_valid, bus.c_valid},
          {29'd0, vecs[i].e_av, vecs[i].e_bv, vecs[i].e_cv});
      chk($sformatf("v%0d_data", i), {8'd0, bus.a, bus.b, bus.c},
          {8'd0, vecs[i].e_a, vecs[i].e_b, vecs[i].e_c});
      chk($sformatf("v%0d_drop", i), 32'(bus.drop_cnt), 32'd0);
    end

`ifdef MY_DEMUX_BROADCAST_EN
    // Broadcast beat
    @(negedge clk);
    drive(1'b1, 2'b11, 8'hC3, 1'b1, 1'b1, 1'b1);
    #1;
    chk("bc_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bc_valids", {29'd0, bus.a_valid, bus.b_valid, bus.c_valid}, 32'd7);
    chk("bc_data", {8'd0, bus.a, bus.b, bus.c}, 32'h00C3C3C3);
    chk("bc_drop", 32'(bus.drop_cnt), 32'd0);
`else
    // 300 illegal beats saturate the drop counter
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b1, 2'b11, 8'(i), 1'b1, 1'b1, 1'b1);
      #1;
      if (i == 0) chk("ill_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("ill%0d_valids", i), {29'd0, bus.a_valid, bus.b_valid, bus.c_valid}, 32'd0);
      if (i == 0 || i == 253 || i == 254 || i == 299)
        chk($sformatf("ill%0d_drop", i), 32'(bus.drop_cnt), (i < 255) ? 32'(i + 1) : 32'hFF);
    end
`endif

    // Stall channel a, then reset asynchronously mid-cycle
    @(negedge clk);
    drive(1'b1, 2'b00, 8'hE1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("stall_a_valid", 32'(bus.a_valid), 32'd1);
    chk("stall_a_data", 32'(bus.a), 32'hE1);
    @(negedge clk);
    drive(1'b0, 2'b11, 8'h00, 1'b0, 1'b1, 1'b1);
    #1;
`ifdef MY_DEMUX_BROADCAST_EN
    chk("stall_x_in_ready", 32'(bus.in_ready), 32'd0);
`else
    chk("stall_x_in_ready", 32'(bus.in_ready), 32'd1);
    chk("stall_drop", 32'(bus.drop_cnt), 32'hFF);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_a_valid", 32'(bus.a_valid), 32'd0);
    chk("arst_a_data", 32'(bus.a), 32'd0);
    chk("arst_drop", 32'(bus.drop_cnt), 32'd0);
    chk("arst_x_in_ready", 32'(bus.in_ready), 32'd1);
    {bus.s1, bus.s0} = 2'b00;
    #1;
    chk("arst_a_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Traffic resumes after reset
    @(negedge clk);
    drive(1'b1, 2'b10, 8'h7E, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("post_valids", {29'd0, bus.a_valid, bus.b_valid, bus.c_valid}, 32'd1);
    chk("post_c", 32'(bus.c), 32'h7E);
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
